// File: rtl/control_options_bank.sv
// rtl/control_options_bank.sv - ZX-Uno option register bank with shadow/active copies and write locks
// Writes land in a shadow copy; the active copy follows on apply (or at once when IMMEDIATE=1).
module control_options_bank #(
    parameter int                 NREGS       = 2,
    parameter logic [7:0]         BASE_ADDR   = 8'h0E,
    parameter logic [7:0]         LOCK_ADDR   = 8'h10,
    parameter logic [NREGS*8-1:0] RESET_VALUE = '0,
    parameter logic [NREGS*8-1:0] WMASK       = '1,
    parameter bit                 IMMEDIATE   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           zxuno_addr,
    input  logic                 zxuno_regrd,
    input  logic                 zxuno_regwr,
    input  logic [7:0]           din,
    input  logic                 apply,
    output logic [7:0]           dout,
    output logic                 oe_n,
    output logic [NREGS*8-1:0]   options,
    output logic [NREGS-1:0]     changed,
    output logic [NREGS-1:0]     pending
);

    logic                 regwr_q;
    logic [NREGS*8-1:0]   shadow_q, shadow_d;
    logic [NREGS*8-1:0]   active_q, active_d;
    logic [NREGS-1:0]     lock_q, lock_d;
    logic [NREGS-1:0]     changed_q, changed_d;
    logic [NREGS-1:0]     pending_q, pending_d;

    logic                 wr_ev;
    logic                 lock_hit;
    logic [NREGS-1:0]     reg_hit;
    logic [7:0]           lock_ext;

    assign wr_ev    = zxuno_regwr & ~regwr_q;
    assign lock_hit = (zxuno_addr == LOCK_ADDR);

    always_comb begin
        reg_hit = '0;
        for (int i = 0; i < NREGS; i++) begin
            reg_hit[i] = (zxuno_addr == (BASE_ADDR + 8'(i)));
        end
    end

    // Read-only bits always carry their reset value, so a write can never disturb them.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_ev && reg_hit[i] && !lock_q[i]) begin
                shadow_d[i*8 +: 8] = (din & WMASK[i*8 +: 8]) |
                                     (RESET_VALUE[i*8 +: 8] & ~WMASK[i*8 +: 8]);
            end
        end
    end

    always_comb begin
        lock_d = lock_q;
        if (wr_ev && lock_hit) begin
            lock_d = lock_q | din[NREGS-1:0];
        end
    end

    // apply commits the pre-write shadow, so a same-cycle write stays pending.
    always_comb begin
        active_d = active_q;
        if (IMMEDIATE) begin
            active_d = shadow_d;
        end else if (apply) begin
            active_d = shadow_q;
        end
    end

    always_comb begin
        changed_d = '0;
        pending_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            changed_d[i] = (active_d[i*8 +: 8] != active_q[i*8 +: 8]);
            pending_d[i] = (shadow_d[i*8 +: 8] != active_d[i*8 +: 8]);
        end
    end

    // The edge detector follows the strobe during reset so a strobe held across release is not a write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regwr_q   <= zxuno_regwr;
            shadow_q  <= RESET_VALUE;
            active_q  <= RESET_VALUE;
            lock_q    <= '0;
            changed_q <= '0;
            pending_q <= '0;
        end else begin
            regwr_q   <= zxuno_regwr;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            lock_q    <= lock_d;
            changed_q <= changed_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        lock_ext = '0;
        lock_ext[NREGS-1:0] = lock_q;
    end

    always_comb begin
        dout = 8'hFF;
        oe_n = 1'b1;
        if (zxuno_regrd) begin
            if (lock_hit) begin
                dout = lock_ext;
                oe_n = 1'b0;
            end
            for (int i = 0; i < NREGS; i++) begin
                if (reg_hit[i]) begin
                    dout = shadow_q[i*8 +: 8];
                    oe_n = 1'b0;
                end
            end
        end
    end

    assign options = active_q;
    assign changed = changed_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_control_options_bank.sv
// tb/tb_control_options_bank.sv - directed self-checking bench for control_options_bank
// dut0: defaults; dut1: masked low nibble with reset value 30; dut2: IMMEDIATE=1.
module tb_control_options_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  zaddr = 8'h00;
    logic        regrd = 1'b0;
    logic        regwr = 1'b0;
    logic [7:0]  din = 8'h00;
    logic        apply = 1'b0;

    logic [7:0]  dout0, dout1, dout2;
    logic        oe0, oe1, oe2;
    logic [15:0] opt0, opt1, opt2;
    logic [1:0]  chg0, chg1, chg2;
    logic [1:0]  pnd0, pnd1, pnd2;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    control_options_bank dut0 (
        .clk(clk), .rst_n(rst_n), .zxuno_addr(zaddr), .zxuno_regrd(regrd),
        .zxuno_regwr(regwr), .din(din), .apply(apply), .dout(dout0), .oe_n(oe0),
        .options(opt0), .changed(chg0), .pending(pnd0)
    );

    control_options_bank #(.RESET_VALUE(16'h0030), .WMASK(16'hFF0F)) dut1 (
        .clk(clk), .rst_n(rst_n), .zxuno_addr(zaddr), .zxuno_regrd(regrd),
        .zxuno_regwr(regwr), .din(din), .apply(apply), .dout(dout1), .oe_n(oe1),
        .options(opt1), .changed(chg1), .pending(pnd1)
    );

    control_options_bank #(.IMMEDIATE(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .zxuno_addr(zaddr), .zxuno_regrd(regrd),
        .zxuno_regwr(regwr), .din(din), .apply(apply), .dout(dout2), .oe_n(oe2),
        .options(opt2), .changed(chg2), .pending(pnd2)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
        zaddr = a; din = d; regwr = 1'b1;
        step();
        regwr = 1'b0;
        step();
    endtask

    task automatic apply_pulse;
        apply = 1'b1;
        step();
        apply = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        vec_cnt++; if (opt0 !== 16'h0000) begin err_cnt++; $display("FAIL reset_options0: got %h expected %h", opt0, 16'h0000); end
        vec_cnt++; if (pnd0 !== 2'b00) begin err_cnt++; $display("FAIL reset_pending0: got %b expected %b", pnd0, 2'b00); end
        vec_cnt++; if (chg0 !== 2'b00) begin err_cnt++; $display("FAIL reset_changed0: got %b expected %b", chg0, 2'b00); end
        vec_cnt++; if (opt1 !== 16'h0030) begin err_cnt++; $display("FAIL reset_options1: got %h expected %h", opt1, 16'h0030); end
        vec_cnt++; if (oe0 !== 1'b1 || dout0 !== 8'hFF) begin err_cnt++; $display("FAIL reset_idle_read: got oe_n=%b dout=%h expected oe_n=1 dout=ff", oe0, dout0); end
    endtask

    task automatic test_write_strobe;
        zaddr = 8'h0E; din = 8'hA5; regwr = 1'b1;
        step();
        vec_cnt++; if (opt2 !== 16'h00A5) begin err_cnt++; $display("FAIL imm_options: got %h expected %h", opt2, 16'h00A5); end
        vec_cnt++; if (chg2 !== 2'b01) begin err_cnt++; $display("FAIL imm_changed: got %b expected %b", chg2, 2'b01); end
        vec_cnt++; if (pnd2 !== 2'b00) begin err_cnt++; $display("FAIL imm_pending: got %b expected %b", pnd2, 2'b00); end
        din = 8'h5A;
        step(); step(); step();
        regwr = 1'b0;
        step();
        regrd = 1'b1;
        #1;
        vec_cnt++; if (oe0 !== 1'b0 || dout0 !== 8'hA5) begin err_cnt++; $display("FAIL strobe_one_write: got oe_n=%b dout=%h expected oe_n=0 dout=a5", oe0, dout0); end
        regrd = 1'b0;
        vec_cnt++; if (opt0 !== 16'h0000) begin err_cnt++; $display("FAIL strobe_not_active: got %h expected %h", opt0, 16'h0000); end
        vec_cnt++; if (pnd0 !== 2'b01) begin err_cnt++; $display("FAIL strobe_pending: got %b expected %b", pnd0, 2'b01); end
        vec_cnt++; if (pnd1 !== 2'b01) begin err_cnt++; $display("FAIL strobe_pending1: got %b expected %b", pnd1, 2'b01); end
        apply_pulse();
        vec_cnt++; if (opt0 !== 16'h00A5) begin err_cnt++; $display("FAIL apply_options: got %h expected %h", opt0, 16'h00A5); end
        vec_cnt++; if (chg0 !== 2'b01) begin err_cnt++; $display("FAIL apply_changed: got %b expected %b", chg0, 2'b01); end
        vec_cnt++; if (pnd0 !== 2'b00) begin err_cnt++; $display("FAIL apply_pending: got %b expected %b", pnd0, 2'b00); end
        vec_cnt++; if (opt1 !== 16'h0035) begin err_cnt++; $display("FAIL apply_masked: got %h expected %h", opt1, 16'h0035); end
        vec_cnt++; if (chg2 !== 2'b00 || pnd2 !== 2'b00) begin err_cnt++; $display("FAIL imm_apply_ignored: got chg=%b pnd=%b expected 00 00", chg2, pnd2); end
        step();
        vec_cnt++; if (chg0 !== 2'b00) begin err_cnt++; $display("FAIL changed_one_cycle: got %b expected %b", chg0, 2'b00); end
    endtask

    task automatic test_wmask;
        write_reg(8'h0E, 8'hFF);
        apply_pulse();
        vec_cnt++; if (opt1 !== 16'h003F) begin err_cnt++; $display("FAIL wmask_options: got %h expected %h", opt1, 16'h003F); end
        vec_cnt++; if (opt0 !== 16'h00FF) begin err_cnt++; $display("FAIL wmask_full: got %h expected %h", opt0, 16'h00FF); end
    endtask

    task automatic test_lock;
        write_reg(8'h10, 8'h01);
        write_reg(8'h0E, 8'h55);
        vec_cnt++; if (pnd0 !== 2'b00) begin err_cnt++; $display("FAIL lock_no_pending: got %b expected %b", pnd0, 2'b00); end
        regrd = 1'b1; zaddr = 8'h0E; #1;
        vec_cnt++; if (dout0 !== 8'hFF) begin err_cnt++; $display("FAIL lock_shadow_held: got %h expected %h", dout0, 8'hFF); end
        zaddr = 8'h10; #1;
        vec_cnt++; if (oe0 !== 1'b0 || dout0 !== 8'h01) begin err_cnt++; $display("FAIL lock_read: got oe_n=%b dout=%h expected oe_n=0 dout=01", oe0, dout0); end
        regrd = 1'b0;
        write_reg(8'h10, 8'h00);
        regrd = 1'b1; zaddr = 8'h10; #1;
        vec_cnt++; if (dout0 !== 8'h01) begin err_cnt++; $display("FAIL lock_set_only: got %h expected %h", dout0, 8'h01); end
        regrd = 1'b0;
    endtask

    task automatic test_same_cycle;
        zaddr = 8'h0F; din = 8'h11; regwr = 1'b1; apply = 1'b1;
        step();
        regwr = 1'b0; apply = 1'b0;
        vec_cnt++; if (opt0[15:8] !== 8'h00) begin err_cnt++; $display("FAIL same_cycle_options: got %h expected %h", opt0[15:8], 8'h00); end
        vec_cnt++; if (pnd0 !== 2'b10) begin err_cnt++; $display("FAIL same_cycle_pending: got %b expected %b", pnd0, 2'b10); end
        step();
        apply_pulse();
        vec_cnt++; if (opt0[15:8] !== 8'h11) begin err_cnt++; $display("FAIL next_apply_options: got %h expected %h", opt0[15:8], 8'h11); end
        vec_cnt++; if (chg0 !== 2'b10) begin err_cnt++; $display("FAIL next_apply_changed: got %b expected %b", chg0, 2'b10); end
    endtask

    task automatic test_reapply;
        step();
        apply_pulse();
        vec_cnt++; if (chg0 !== 2'b00) begin err_cnt++; $display("FAIL reapply_changed: got %b expected %b", chg0, 2'b00); end
        vec_cnt++; if (opt0 !== 16'h11FF) begin err_cnt++; $display("FAIL reapply_options: got %h expected %h", opt0, 16'h11FF); end
        regrd = 1'b1; zaddr = 8'h20; #1;
        vec_cnt++; if (oe0 !== 1'b1 || dout0 !== 8'hFF) begin err_cnt++; $display("FAIL unmapped_read: got oe_n=%b dout=%h expected oe_n=1 dout=ff", oe0, dout0); end
        regrd = 1'b0; zaddr = 8'h0E; #1;
        vec_cnt++; if (oe0 !== 1'b1 || dout0 !== 8'hFF) begin err_cnt++; $display("FAIL no_read: got oe_n=%b dout=%h expected oe_n=1 dout=ff", oe0, dout0); end
    endtask

    task automatic test_read_during_write;
        zaddr = 8'h0F; regrd = 1'b1; din = 8'h77; regwr = 1'b1;
        #1;
        vec_cnt++; if (dout0 !== 8'h11) begin err_cnt++; $display("FAIL rdwr_pre_value: got %h expected %h", dout0, 8'h11); end
        step();
        vec_cnt++; if (dout0 !== 8'h77) begin err_cnt++; $display("FAIL rdwr_post_value: got %h expected %h", dout0, 8'h77); end
        regwr = 1'b0; regrd = 1'b0;
        step();
    endtask

    task automatic test_back_to_back;
        zaddr = 8'h0F; din = 8'h12; regwr = 1'b1;
        step();
        regwr = 1'b0;
        step();
        din = 8'h34; regwr = 1'b1;
        step();
        regwr = 1'b0;
        step();
        regrd = 1'b1; #1;
        vec_cnt++; if (dout0 !== 8'h34) begin err_cnt++; $display("FAIL back_to_back: got %h expected %h", dout0, 8'h34); end
        regrd = 1'b0;
    endtask

    task automatic test_reset_midstrobe;
        write_reg(8'h0F, 8'h22);
        write_reg(8'h10, 8'hFF);
        vec_cnt++; if (pnd0 !== 2'b10) begin err_cnt++; $display("FAIL pre_reset_pending: got %b expected %b", pnd0, 2'b10); end
        regrd = 1'b1; zaddr = 8'h10; #1;
        vec_cnt++; if (dout0 !== 8'h03) begin err_cnt++; $display("FAIL lock_width: got %h expected %h", dout0, 8'h03); end
        regrd = 1'b0;
        zaddr = 8'h0E; din = 8'h99; regwr = 1'b1; rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step(); step();
        regwr = 1'b0;
        step();
        vec_cnt++; if (opt0 !== 16'h0000 || pnd0 !== 2'b00 || chg0 !== 2'b00) begin err_cnt++; $display("FAIL midreset_state: got opt=%h pnd=%b chg=%b expected 0000 00 00", opt0, pnd0, chg0); end
        regrd = 1'b1; zaddr = 8'h0E; #1;
        vec_cnt++; if (dout0 !== 8'h00) begin err_cnt++; $display("FAIL midreset_no_write: got %h expected %h", dout0, 8'h00); end
        vec_cnt++; if (dout1 !== 8'h30) begin err_cnt++; $display("FAIL midreset_resetval1: got %h expected %h", dout1, 8'h30); end
        zaddr = 8'h0F; #1;
        vec_cnt++; if (dout0 !== 8'h00) begin err_cnt++; $display("FAIL midreset_reg1: got %h expected %h", dout0, 8'h00); end
        zaddr = 8'h10; #1;
        vec_cnt++; if (dout0 !== 8'h00) begin err_cnt++; $display("FAIL midreset_lock: got %h expected %h", dout0, 8'h00); end
        regrd = 1'b0;
        vec_cnt++; if (opt1 !== 16'h0030) begin err_cnt++; $display("FAIL midreset_options1: got %h expected %h", opt1, 16'h0030); end
        write_reg(8'h0E, 8'h42);
        regrd = 1'b1; zaddr = 8'h0E; #1;
        vec_cnt++; if (dout0 !== 8'h42) begin err_cnt++; $display("FAIL unlocked_after_reset: got %h expected %h", dout0, 8'h42); end
        regrd = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_strobe();
        test_wmask();
        test_lock();
        test_same_cycle();
        test_reapply();
        test_read_during_write();
        test_back_to_back();
        test_reset_midstrobe();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
